decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4-to-16 enabled decoder output bus among 16 requesters. It picks one requester at a time, holds the grant until the requester releases or a hold limit expires, and drives the binary grant index through an internal enabled decoder to produce a one-hot grant. It sits in front of the decoder datapath and replaces free-running `binary_in`/`enable` drive with a sequenced, fair schedule.

---
 rtl/decoder_arb_pkg.sv | 35 +++
 rtl/decoder_4to16_en.sv | 16 +
 rtl/decoder_rr_arbiter.sv | 119 +++++++++++
 tb/tb_decoder_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared types and helpers for the 16-way round-robin decoder arbiter.
// Pure declarations; no latency or flow control of its own.
package decoder_arb_pkg;

    localparam int ARB_N     = 16;
    localparam int ARB_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    // Bit i of the result is bit (i + sh) mod ARB_N of v, so bit 0 is the search start.
    function automatic logic [ARB_N-1:0] rot_right(input logic [ARB_N-1:0] v,
                                                   input logic [ARB_IDX_W-1:0] sh);
        logic [ARB_N-1:0] r;
        r = '0;
        for (int i = 0; i < ARB_N; i++) begin
            r[i] = v[ARB_IDX_W'(i) + sh];
        end
        return r;
    endfunction

    // Returns {found, index of lowest set bit}.
    function automatic logic [ARB_IDX_W:0] find_first(input logic [ARB_N-1:0] v);
        logic [ARB_IDX_W:0] res;
        res = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (v[i]) res = {1'b1, ARB_IDX_W'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_4to16_en.sv
// Enabled 4-to-16 one-hot decoder; purely combinational, zero latency.
// No flow control: output is all zero whenever enable is low.
module decoder_4to16_en
    import decoder_arb_pkg::*;
(
    input  logic [ARB_IDX_W-1:0] binary_in,
    input  logic                 enable,
    output logic [ARB_N-1:0]     decoder_out
);

    always_comb begin
        decoder_out = '0;
        if (enable) decoder_out[binary_in] = 1'b1;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin grant of a 4-to-16 decoder bus to 16 requesters, held until release or MAX_HOLD.
// 1-cycle request-to-grant; handover back-to-back, or with one dead cycle under DECODER_ARB_GUARD_EN.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [ARB_N-1:0]     req,
    output logic                 grant_valid,
    output logic [ARB_IDX_W-1:0] grant_index,
    output logic [ARB_N-1:0]     grant_onehot,
    output logic                 timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [ARB_IDX_W-1:0] ptr;
    logic [ARB_IDX_W-1:0] ptr_nxt;
    logic [ARB_IDX_W-1:0] index_nxt;
    logic [ARB_IDX_W-1:0] start;
    logic [ARB_IDX_W-1:0] offset;
    logic [ARB_IDX_W-1:0] winner;
    logic [7:0]           hold_cnt;
    logic [7:0]           hold_nxt;
    logic [ARB_N-1:0]     cand;
    logic [ARB_N-1:0]     rot;
    logic                 found;
    logic                 hold_last;
    logic                 held_req;
    logic                 release_now;
    logic                 forced;
    logic                 timeout_nxt;

    assign grant_valid = (state == GRANT);

    decoder_4to16_en u_dec (
        .binary_in   (grant_index),
        .enable      (grant_valid),
        .decoder_out (grant_onehot)
    );

    // While granted, the search starts just past the owner and skips it; this is exactly
    // where ptr lands on release, so one search serves both IDLE and handover.
    always_comb begin
        start           = grant_valid ? grant_index + 4'd1 : ptr;
        cand            = req & ~grant_onehot;
        rot             = rot_right(cand, start);
        {found, offset} = find_first(rot);
        winner          = start + offset;
    end

    assign hold_last   = (hold_cnt == HOLD_LAST);
    assign held_req    = req[grant_index];
    assign release_now = !held_req || hold_last;
    assign forced      = held_req && hold_last;

    always_comb begin
        state_nxt   = state;
        index_nxt   = grant_index;
        hold_nxt    = hold_cnt;
        ptr_nxt     = ptr;
        timeout_nxt = 1'b0;
        case (state)
            GRANT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_index + 4'd1;
                end else if (release_now) begin
                    ptr_nxt     = grant_index + 4'd1;
                    timeout_nxt = forced;
`ifdef DECODER_ARB_GUARD_EN
                    state_nxt   = GUARD;
`else
                    if (found) begin
                        state_nxt = GRANT;
                        index_nxt = winner;
                        hold_nxt  = 8'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                if (enable && found) begin
                    state_nxt = GRANT;
                    index_nxt = winner;
                    hold_nxt  = 8'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_index <= '0;
            hold_cnt    <= 8'd0;
            ptr         <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_index <= index_nxt;
            hold_cnt    <= hold_nxt;
            ptr         <= ptr_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: two instances (MAX_HOLD 8 and 2) against an ownership-level model.
// Honours DECODER_ARB_GUARD_EN for the handover gap.
module tb_decoder_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] req = 16'h0;

    logic        gv_a, to_a, gv_b, to_b;
    logic [3:0]  gi_a, gi_b;
    logic [15:0] go_a, go_b;
    logic [21:0] obs [2];

    int total = 0;
    int bad   = 0;

    int m_owner [2];
    int m_held  [2];
    int m_ptr   [2];
    bit m_to    [2];
    int m_mh    [2];

    always #5 clk = ~clk;

    decoder_rr_arbiter u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .req(req),
        .grant_valid(gv_a), .grant_index(gi_a), .grant_onehot(go_a), .timeout(to_a)
    );

    decoder_rr_arbiter #(.MAX_HOLD(2)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .req(req),
        .grant_valid(gv_b), .grant_index(gi_b), .grant_onehot(go_b), .timeout(to_b)
    );

    always_comb begin
        obs[0] = {gv_a, gv_a ? gi_a : 4'd0, go_a, to_a};
        obs[1] = {gv_b, gv_b ? gi_b : 4'd0, go_b, to_b};
    end

    function automatic int pick(int start, logic [15:0] r, int excl);
        for (int i = 0; i < 16; i++) begin
            int c;
            c = (start + i) % 16;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic logic [21:0] exp_vec(int k);
        logic        v;
        logic [3:0]  i;
        logic [15:0] oh;
        v  = (m_owner[k] >= 0);
        i  = v ? 4'(m_owner[k]) : 4'd0;
        oh = v ? (16'd1 << m_owner[k]) : 16'd0;
        return {v, i, oh, m_to[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_ptr[k]   = 0;
            m_to[k]    = 1'b0;
        end
    endtask

    // One clock of the reference: an owner keeps the bus until it lets go or uses up MAX_HOLD cycles.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit nto;
            int prev;
            nto = 1'b0;
            if (!enable) begin
                if (m_owner[k] >= 0) m_ptr[k] = (m_owner[k] + 1) % 16;
                m_owner[k] = -1;
            end else if (m_owner[k] < 0) begin
                m_owner[k] = pick(m_ptr[k], req, -1);
                m_held[k]  = 0;
            end else if (!req[m_owner[k]] || m_held[k] == m_mh[k] - 1) begin
                nto      = req[m_owner[k]];
                prev     = m_owner[k];
                m_ptr[k] = (prev + 1) % 16;
`ifdef DECODER_ARB_GUARD_EN
                m_owner[k] = -1;
`else
                m_owner[k] = pick(m_ptr[k], req, prev);
                m_held[k]  = 0;
`endif
            end else begin
                m_held[k]++;
            end
            m_to[k] = nto;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        req     = 16'hFFFF;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 22'd0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=%h", k, obs[k], 22'd0);
            end
        end
        total++;
        if (gi_a !== 4'd0) begin
            bad++;
            $display("FAIL reset_index got=%0d exp=0", gi_a);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (obs[0] !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin
            bad++;
            $display("FAIL first_grant got=%h exp=%h", obs[0], {1'b1, 4'd0, 16'h0001, 1'b0});
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
                bad++;
                $display("FAIL first_grant_model inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        enable = 1'b1;
        req    = 16'h8001;
        for (int c = 0; c < 16; c++) begin
            logic [3:0] ei;
            logic       et;
            tick();
            ei = ((c / 2) % 2 == 1) ? 4'd15 : 4'd0;
            et = (c >= 2) && (c % 2 == 0);
`ifndef DECODER_ARB_GUARD_EN
            total++;
            if (gv_b !== 1'b1 || gi_b !== ei || to_b !== et) begin
                bad++;
                $display("FAIL fairness_seq cyc=%0d got=%b/%0d/%b exp=1/%0d/%b",
                         c, gv_b, gi_b, to_b, ei, et);
            end
`endif
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL fairness inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1;
        req    = 16'h2000;
        tick();
        req = 16'h0000;
        tick();
        req = 16'h0003;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) begin
                total++;
                if (gv_a !== 1'b1 || gi_a !== 4'd0) begin
                    bad++;
                    $display("FAIL wrap_first got=%b/%0d exp=1/0", gv_a, gi_a);
                end
            end
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL wrap inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_voluntary();
        do_reset();
        enable = 1'b1;
        req    = 16'h0020;
        tick();
        req = 16'h0220;
        repeat (2) tick();
        req = 16'h0200;
        tick();
`ifdef DECODER_ARB_GUARD_EN
        total++;
        if (gv_a !== 1'b0 || to_a !== 1'b0) begin
            bad++;
            $display("FAIL voluntary_gap got=%b/%b exp=0/0", gv_a, to_a);
        end
        tick();
`endif
        total++;
        if (gv_a !== 1'b1 || gi_a !== 4'd9 || to_a !== 1'b0) begin
            bad++;
            $display("FAIL voluntary_next got=%b/%0d/%b exp=1/9/0", gv_a, gi_a, to_a);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
                bad++;
                $display("FAIL voluntary inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b1;
        req    = 16'h0008;
        tick();
        tick();
        enable = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 22'd0) begin
                bad++;
                $display("FAIL enable_off inst=%0d got=%h exp=%h", k, obs[k], 22'd0);
            end
        end
        enable = 1'b1;
        tick();
        total++;
        if (gv_a !== 1'b1 || gi_a !== 4'd3 || go_a !== 16'h0008) begin
            bad++;
            $display("FAIL enable_regrant got=%b/%0d/%h exp=1/3/0008", gv_a, gi_a, go_a);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
                bad++;
                $display("FAIL enable_model inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        req    = 16'h0040;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== 22'd0) begin
                bad++;
                $display("FAIL async_reset inst=%0d got=%h exp=%h", k, obs[k], 22'd0);
            end
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== exp_vec(k)) begin
                bad++;
                $display("FAIL async_resume inst=%0d got=%h exp=%h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) != 0) req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_vec(k)) begin
                    bad++;
                    $display("FAIL random inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        m_mh[0] = 8;
        m_mh[1] = 2;
        model_reset();
        @(negedge clk);
        test_reset();
        test_fairness();
        test_wrap();
        test_voluntary();
        test_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
